mux_scan_sequencer: RTL and testbench
=====================================

Name: mux_scan_sequencer

Overview:
- Scan controller that drives the 3-bit select of the 8:1 multiplexer and captures its output.
- On each start request it steps sel through 0..7 and waits a programmable settle time per channel.
- It samples the mux output once per channel and assembles the 8 samples into one byte.
- The byte is offered downstream with a valid/ready handshake.

Parameters:
- SETTLE, default 1: extra wait cycles after sel changes before mux_out is sampled. Legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  scan request, sampled only in IDLE (or on the completing handshake cycle).
- mux_out  input  1  output of the 8:1 mux, combinationally driven from sel.
- sel  output  3  channel select to the mux.
- busy  output  1  high while a scan is in progress (state SCAN).
- data_out  output  8  assembled byte; bit i = sample taken with sel=i.
- data_valid  output  1  data_out holds a complete scan.
- data_ready  input  1  downstream accepts data_out.

Behaviour:
- One clock domain. Reset is asynchronous, active-low; all flops clear immediately on rst_n=0.
- Reset values: sel=0, busy=0, data_out=8'h00, data_valid=0, state=IDLE, settle counter cnt=SETTLE, parity=0.
- States and transitions:
  - IDLE: sel=0, busy=0. If start=1 at an edge: go to SCAN, sel=0, cnt=SETTLE, busy=1.
  - SCAN, when cnt!=0: cnt decrements each edge.
  - SCAN, when cnt==0: that edge captures mux_out into data_out[sel].
    - If sel<7: sel increments and cnt reloads to SETTLE.
    - If sel==7: go to DONE, data_valid=1, busy=0, sel stays 7.
  - DONE: data_out and data_valid are held stable until data_valid&data_ready at an edge.
    - On that edge data_valid drops.
    - If start=1 on the same edge: go directly to SCAN with sel=0, cnt=SETTLE, busy=1.
    - Otherwise go to IDLE and sel returns to 0.
- Latency: start accepted at edge E0 gives data_valid=1 after edge E0 + 8*(SETTLE+1).
  - SETTLE=1: 16 cycles. SETTLE=0: 8 cycles, one channel per clock.
- start in SCAN is ignored and not queued.
- data_ready outside DONE is ignored.
- Bits of data_out not yet captured in the current scan keep their previous-scan values until overwritten; only the final byte at data_valid is defined.
- sel changes only on clock edges. Each channel stays selected for SETTLE+1 cycles, and the sample is taken at the last of those edges.
- rst_n asserted mid-scan or in DONE: immediate return to reset values; the partial byte is discarded and no data_valid is produced.
- Width rules: cnt is 4 bits. sel wraps never; the 7-to-DONE transition replaces increment.

Optional Feature:
- Macro SCAN_PARITY_EN.
- Defined:
  - Adds output port data_parity (1 bit).
  - data_parity equals the XOR of all 8 captured bits (even parity: data_out plus parity has even number of ones).
  - Registered on the DONE-entry edge together with data_valid.
  - Held stable with data_out; reset value 0.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Basic scan: mux inputs d7..d0=8'b1011_0010, SETTLE=1, pulse start -> sel steps 0..7 every 2 cycles; data_valid high 16 cycles after the start edge; data_out=8'hB2; data_ready=1 returns to IDLE with sel=0.
- Back-pressure: same inputs, data_ready=0 for 10 cycles after data_valid -> data_out=8'hB2 and data_valid held; mux inputs changed to 8'h00 meanwhile do not alter data_out; release data_ready -> one handshake, then IDLE.
- Start while busy plus back-to-back: start pulsed at cycles 3 and 9 of a scan -> ignored, exactly one result; start=1 on the handshake edge with inputs 8'h5A -> new scan begins immediately, next data_out=8'h5A.
- Reset mid-scan: assert rst_n=0 at sel=4 -> sel=0, busy=0, data_valid=0, data_out=8'h00 immediately without waiting for a clock; a fresh scan then yields the correct byte.
- SETTLE=0: inputs 8'hFF then 8'h01 -> data_valid 8 cycles after start; data_out=8'hFF, then 8'h01.
- SCAN_PARITY_EN defined: 8'hB2 gives data_parity=0; 8'hB3 gives data_parity=1; port absent when the macro is undefined.

Source files
------------

// File: rtl/mux_scan_sequencer_if.sv
// Bundle between the scan sequencer and its surroundings (mux + downstream).
// Optional feature macro: SCAN_PARITY_EN adds the data_parity signal.
//
// Handshake: data_out (and data_parity) are valid whenever data_valid=1 and
// stay stable until a rising edge sees data_valid & data_ready, which
// transfers the byte.
interface mux_scan_sequencer_if;
    logic       start;
    logic       mux_out;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready;
    logic [1:0] state;        // debug view of the controller state
`ifdef SCAN_PARITY_EN
    logic       data_parity;
`endif

`ifdef SCAN_PARITY_EN
    modport master (
        input  start, mux_out, data_ready,
        output sel, busy, data_out, data_valid, state, data_parity
    );
    modport slave (
        output start, mux_out, data_ready,
        input  sel, busy, data_out, data_valid, state, data_parity
    );
`else
    modport master (
        input  start, mux_out, data_ready,
        output sel, busy, data_out, data_valid, state
    );
    modport slave (
        output start, mux_out, data_ready,
        input  sel, busy, data_out, data_valid, state
    );
`endif
endinterface

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8:1 mux: steps sel 0..7, waits SETTLE extra cycles
// per channel, samples mux_out into data_out[sel] and offers the byte with a
// valid/ready handshake.
// Optional feature macro: SCAN_PARITY_EN (registered even-parity output).
module mux_scan_sequencer #(
    parameter int unsigned SETTLE = 1   // 0..15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    mux_scan_sequencer_if.master    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] data_q, data_d;
`ifdef SCAN_PARITY_EN
    logic       parity_q, parity_d;
`endif

    // Next-state and datapath: one channel is sampled when its settle count runs out.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
`ifdef SCAN_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                if (bus.start) begin
                    state_d = SCAN;
                    cnt_d   = SETTLE_LD;
                end
            end
            SCAN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d[sel_q] = bus.mux_out;
                    if (sel_q != 3'd7) begin
                        sel_d = sel_q + 3'd1;
                        cnt_d = SETTLE_LD;
                    end else begin
                        // sel holds at 7 while the result is offered
                        state_d  = DONE;
`ifdef SCAN_PARITY_EN
                        parity_d = ^data_d;
`endif
                    end
                end
            end
            DONE: begin
                if (bus.data_ready) begin
                    sel_d = 3'd0;
                    if (bus.start) begin
                        state_d = SCAN;
                        cnt_d   = SETTLE_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = 3'd0;
                cnt_d   = SETTLE_LD;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            cnt_q    <= SETTLE_LD;
            data_q   <= 8'h00;
`ifdef SCAN_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
`ifdef SCAN_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // busy and data_valid are decoded straight from the state register.
    assign bus.sel        = sel_q;
    assign bus.busy       = (state_q == SCAN);
    assign bus.data_valid = (state_q == DONE);
    assign bus.data_out   = data_q;
    assign bus.state      = state_q;
`ifdef SCAN_PARITY_EN
    assign bus.data_parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: one instance with SETTLE=1 and one with
// SETTLE=0, each driving a modelled 8:1 mux built from an 8-bit pattern.
// Optional feature macro: SCAN_PARITY_EN (parity checks compiled in).
module tb_mux_scan_sequencer;

    logic clk;
    logic rst_n;
    logic [7:0] pat0, pat1;
    int n_checks;
    int n_fail;

    mux_scan_sequencer_if if0 ();
    mux_scan_sequencer_if if1 ();

    // the mux itself: output follows sel combinationally
    assign if0.mux_out = pat0[if0.sel];
    assign if1.mux_out = pat1[if1.sel];

    mux_scan_sequencer #(.SETTLE(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    mux_scan_sequencer #(.SETTLE(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic st, input logic rd);
        if (d == 0) begin
            if0.start = st; if0.data_ready = rd;
        end else begin
            if1.start = st; if1.data_ready = rd;
        end
    endtask

    task automatic set_pat(input int d, input logic [7:0] p);
        if (d == 0) pat0 = p; else pat1 = p;
    endtask

    task automatic peek(input int d, output logic [2:0] s, output logic b,
                        output logic v, output logic [7:0] o);
        if (d == 0) begin
            s = if0.sel; b = if0.busy; v = if0.data_valid; o = if0.data_out;
        end else begin
            s = if1.sel; b = if1.busy; v = if1.data_valid; o = if1.data_out;
        end
    endtask

    task automatic check_parity(input int d, input logic [7:0] exp_byte);
`ifdef SCAN_PARITY_EN
        logic p;
        p = (d == 0) ? if0.data_parity : if1.data_parity;
        check("data_parity", 32'(p), 32'(^exp_byte));
`endif
    endtask

    // One complete scan checked against the timing rule: channel k/(SETTLE+1)
    // is selected k edges after the start edge; the byte appears 8*(SETTLE+1)
    // edges after it. chained=1 means the start edge has already happened.
    task automatic do_scan(input int d, input logic [7:0] pat, input int hold,
                           input bit chained, input bit poke_start, input bit chain_next);
        logic [2:0] s;
        logic b, v;
        logic [7:0] o;
        int per, len;
        per = (d == 0) ? 2 : 1;
        len = 8 * per;
        set_pat(d, pat);
        if (!chained) begin
            drive(d, 1'b1, 1'b0);
            tick();
            drive(d, 1'b0, 1'b0);
        end
        for (int k = 1; k <= len; k++) begin
            if (poke_start && (k == 3 || k == 9)) drive(d, 1'b1, 1'b0);
            else drive(d, 1'b0, 1'b0);
            tick();
            peek(d, s, b, v, o);
            check("scan_sel", 32'(s), (k < len) ? 32'(k / per) : 32'd7);
            check("scan_busy", 32'(b), 32'(k < len));
            check("scan_valid", 32'(v), 32'(k == len));
        end
        drive(d, 1'b0, 1'b0);
        peek(d, s, b, v, o);
        check("data_out", 32'(o), 32'(pat));
        check_parity(d, pat);
        // back-pressure: the mux changes underneath, result must not
        for (int h = 0; h < hold; h++) begin
            set_pat(d, ~pat);
            tick();
            peek(d, s, b, v, o);
            check("hold_valid", 32'(v), 32'd1);
            check("hold_data", 32'(o), 32'(pat));
            check("hold_sel", 32'(s), 32'd7);
            check("hold_busy", 32'(b), 32'd0);
            check_parity(d, pat);
        end
        drive(d, chain_next, 1'b1);
        tick();
        drive(d, 1'b0, 1'b0);
        peek(d, s, b, v, o);
        check("hs_valid", 32'(v), 32'd0);
        check("hs_sel", 32'(s), 32'd0);
        check("hs_busy", 32'(b), 32'(chain_next));
        if (!chain_next) begin
            tick();
            peek(d, s, b, v, o);
            check("idle_valid", 32'(v), 32'd0);
            check("idle_busy", 32'(b), 32'd0);
        end
    endtask

    initial begin
        logic [2:0] s;
        logic b, v;
        logic [7:0] o;
        bit chained, chain_next;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        pat0 = 8'h00;
        pat1 = 8'h00;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            peek(d, s, b, v, o);
            check("rst_sel", 32'(s), 32'd0);
            check("rst_busy", 32'(b), 32'd0);
            check("rst_valid", 32'(v), 32'd0);
            check("rst_data", 32'(o), 32'd0);
            check_parity(d, 8'h00);
        end
        rst_n = 1'b1;
        tick();

        // data_ready in IDLE does nothing
        drive(0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            peek(0, s, b, v, o);
            check("idle_ready_valid", 32'(v), 32'd0);
            check("idle_ready_busy", 32'(b), 32'd0);
        end
        drive(0, 1'b0, 1'b0);

        // basic scan and back-pressure
        do_scan(0, 8'hB2, 0, 1'b0, 1'b0, 1'b0);
        do_scan(0, 8'hB2, 10, 1'b0, 1'b0, 1'b0);
        // start while busy ignored, then back-to-back start on handshake
        do_scan(0, 8'hC3, 0, 1'b0, 1'b1, 1'b1);
        do_scan(0, 8'h5A, 2, 1'b1, 1'b0, 1'b0);
        // parity odd case
        do_scan(0, 8'hB3, 0, 1'b0, 1'b0, 1'b0);

        // reset mid-scan at sel=4 (8 edges after start for SETTLE=1)
        set_pat(0, 8'h3C);
        drive(0, 1'b1, 1'b0);
        tick();
        drive(0, 1'b0, 1'b0);
        repeat (8) tick();
        peek(0, s, b, v, o);
        check("pre_rst_sel", 32'(s), 32'd4);
        rst_n = 1'b0;
        #1;
        peek(0, s, b, v, o);
        check("async_rst_sel", 32'(s), 32'd0);
        check("async_rst_busy", 32'(b), 32'd0);
        check("async_rst_valid", 32'(v), 32'd0);
        check("async_rst_data", 32'(o), 32'd0);
        check_parity(0, 8'h00);
        #1;
        rst_n = 1'b1;
        tick();
        peek(0, s, b, v, o);
        check("post_rst_busy", 32'(b), 32'd0);
        check("post_rst_valid", 32'(v), 32'd0);
        do_scan(0, 8'h96, 1, 1'b0, 1'b0, 1'b0);

        // SETTLE=0 instance
        do_scan(1, 8'hFF, 0, 1'b0, 1'b0, 1'b0);
        do_scan(1, 8'h01, 3, 1'b0, 1'b0, 1'b0);

        // randomized scans with random back-pressure and chaining
        for (int d = 0; d < 2; d++) begin
            chained = 1'b0;
            for (int i = 0; i < 6; i++) begin
                chain_next = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
                do_scan(d, 8'($urandom), $urandom_range(0, 4), chained,
                        1'($urandom_range(0, 1)), chain_next);
                chained = chain_next;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
